// File: rtl/pll_clken_pkg.sv
// ---------------------------------------------------------------------------
// pll_clken_pkg
//   Shared types and defaults for the lock-supervised clock-enable generator.
//   - state_t       : supervisor states UNLOCKED / SETTLE / RUN
//   - DEF_*         : default parameter values for pll_clken_gen / pll_clken_nco
//   - settle_cnt_w  : width of the settle counter for a given SETTLE_CYC
//   Optional feature macro used by the importing modules: PLL_CLKEN_PHASE_EN
// ---------------------------------------------------------------------------
package pll_clken_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_SETTLE,
    ST_RUN
  } state_t;

  localparam int unsigned DEF_NUM_CH     = 4;
  localparam int unsigned DEF_ACC_W      = 24;
  localparam int unsigned DEF_SETTLE_CYC = 1024;
  localparam int unsigned DEF_LOSS_W     = 8;
  localparam int unsigned DEF_PHASE_W    = 4;

  // Counter only has to reach SETTLE_CYC-1; keep at least one bit.
  function automatic int unsigned settle_cnt_w(input int unsigned cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

endpackage

// File: rtl/pll_clken_nco.sv
// ---------------------------------------------------------------------------
// pll_clken_nco
//   One phase-accumulator enable channel with glitch-free retuning.
//   Ports:
//     refclk   in   clock (rising edge)
//     rst_n    in   asynchronous active-low reset
//     run      in   supervisor is in RUN
//     ch_on    in   channel run enable
//     cfg_we   in   increment write strobe for this channel
//     cfg_inc  in   increment value (ACC_W)
//     clk_en   out  one-cycle enable pulse, registered one cycle after overflow
//     phase    out  top PHASE_W accumulator bits (only with PLL_CLKEN_PHASE_EN)
//   A new increment is staged in pend and only takes effect on a carry cycle
//   while the channel runs, so a period in progress always completes at the
//   old spacing. When the channel is idle the write lands immediately.
// ---------------------------------------------------------------------------
module pll_clken_nco
  import pll_clken_pkg::*;
#(
  parameter int unsigned ACC_W   = DEF_ACC_W
`ifdef PLL_CLKEN_PHASE_EN
  , parameter int unsigned PHASE_W = DEF_PHASE_W
`endif
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             ch_on,
  input  logic             cfg_we,
  input  logic [ACC_W-1:0] cfg_inc,
  output logic             clk_en
`ifdef PLL_CLKEN_PHASE_EN
  , output logic [PHASE_W-1:0] phase
`endif
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] pend;
  logic             pend_v;
  logic             carry;
  logic             active;
  logic [ACC_W:0]   sum;
  logic             ovf;

  assign active = run & ch_on;
  assign sum    = {1'b0, acc} + {1'b0, inc};
  assign ovf    = active & sum[ACC_W];

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      inc    <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
      carry  <= 1'b0;
      clk_en <= 1'b0;
    end else begin
      // Idle channels sit at acc=0, so RUN entry or ch_on rising always
      // starts phase-aligned from zero.
      if (active) begin
        acc   <= sum[ACC_W-1:0];
        carry <= sum[ACC_W];
      end else begin
        acc   <= '0;
        carry <= 1'b0;
      end
      clk_en <= active & carry;

      // A write on a carry cycle bypasses pend and drops any stale value.
      if (cfg_we) begin
        if (!active || ovf) begin
          inc    <= cfg_inc;
          pend_v <= 1'b0;
        end else begin
          pend   <= cfg_inc;
          pend_v <= 1'b1;
        end
      end else if (pend_v && (!active || ovf)) begin
        inc    <= pend;
        pend_v <= 1'b0;
      end
    end
  end

`ifdef PLL_CLKEN_PHASE_EN
  assign phase = acc[ACC_W-1 -: PHASE_W];
`endif

endmodule

// File: rtl/pll_clken_gen.sv
// ---------------------------------------------------------------------------
// pll_clken_gen
//   Multi-channel NCO clock-enable generator gated by PLL lock supervision.
//   Ports:
//     refclk      in   PLL output clock, all logic on rising edge
//     rst_n       in   asynchronous active-low reset
//     pll_locked  in   raw asynchronous PLL lock (2-flop synchronised)
//     cfg_we      in   increment write strobe
//     cfg_ch      in   target channel (out-of-range index ignored)
//     cfg_inc     in   increment value (ACC_W)
//     ch_on       in   per-channel run enable (NUM_CH)
//     clk_en      out  per-channel one-cycle enable pulses (NUM_CH)
//     ready       out  1 while in RUN
//     loss_cnt    out  RUN->UNLOCKED transitions, saturating (LOSS_W)
//     phase       out  per-channel phase bits (NUM_CH*PHASE_W), only with
//                      `define PLL_CLKEN_PHASE_EN
//   Enables are held off until the synchronised lock has been high for
//   SETTLE_CYC consecutive cycles in SETTLE.
// ---------------------------------------------------------------------------
module pll_clken_gen
  import pll_clken_pkg::*;
#(
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned ACC_W      = DEF_ACC_W,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned LOSS_W     = DEF_LOSS_W
`ifdef PLL_CLKEN_PHASE_EN
  , parameter int unsigned PHASE_W  = DEF_PHASE_W
`endif
) (
  input  logic                                        refclk,
  input  logic                                        rst_n,
  input  logic                                        pll_locked,
  input  logic                                        cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]                            cfg_inc,
  input  logic [NUM_CH-1:0]                           ch_on,
  output logic [NUM_CH-1:0]                           clk_en,
  output logic                                        ready,
  output logic [LOSS_W-1:0]                           loss_cnt
`ifdef PLL_CLKEN_PHASE_EN
  , output logic [NUM_CH*PHASE_W-1:0]                 phase
`endif
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SCW  = settle_cnt_w(SETTLE_CYC);

  logic              lock_m;
  logic              lock_s;
  state_t            state;
  logic [SCW-1:0]    settle_cnt;
  logic              run;
  logic [NUM_CH-1:0] ch_we;

  // Lock synchroniser
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  // Supervisor FSM; ready is set on the same edge the state changes so it
  // always equals (state == ST_RUN).
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_UNLOCKED;
      settle_cnt <= '0;
      ready      <= 1'b0;
      loss_cnt   <= '0;
    end else begin
      case (state)
        ST_UNLOCKED: begin
          if (lock_s) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
          end
        end
        ST_SETTLE: begin
          if (!lock_s) begin
            state <= ST_UNLOCKED;
          end else if (settle_cnt == SCW'(SETTLE_CYC - 1)) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + SCW'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state <= ST_UNLOCKED;
            ready <= 1'b0;
            if (loss_cnt != '1) begin
              loss_cnt <= loss_cnt + LOSS_W'(1);
            end
          end
        end
        default: begin
          state <= ST_UNLOCKED;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign run = (state == ST_RUN);

  // Indices >= NUM_CH never match, so such writes are dropped.
  always_comb begin
    ch_we = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        ch_we[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pll_clken_nco #(
      .ACC_W   (ACC_W)
`ifdef PLL_CLKEN_PHASE_EN
      , .PHASE_W (PHASE_W)
`endif
    ) u_nco (
      .refclk  (refclk),
      .rst_n   (rst_n),
      .run     (run),
      .ch_on   (ch_on[g]),
      .cfg_we  (ch_we[g]),
      .cfg_inc (cfg_inc),
      .clk_en  (clk_en[g])
`ifdef PLL_CLKEN_PHASE_EN
      , .phase (phase[g*PHASE_W +: PHASE_W])
`endif
    );
  end

endmodule
